// File: rtl/poseidon2_pkg.sv
// rtl/poseidon2_pkg.sv - shared types and constants for the Poseidon2 hash initiator
package poseidon2_pkg;

    localparam int ELEM_W    = 256;
    localparam int DIGEST_W  = 256;
    localparam int MAX_ELEMS = 15;

    typedef logic [ELEM_W-1:0]   elem_t;
    typedef logic [DIGEST_W-1:0] digest_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_START,
        ST_FEED,
        ST_WAIT,
        ST_RESULT
    } init_state_e;

    typedef enum logic [1:0] {
        HASH_OK         = 2'd0,
        HASH_OVERFLOW   = 2'd1,
        HASH_TIMEOUT    = 2'd2,
        HASH_EARLY_DONE = 2'd3
    } hash_err_e;

endpackage

// File: rtl/poseidon2_msg_buf.sv
// rtl/poseidon2_msg_buf.sv - message element buffer with write pointer and read index
module poseidon2_msg_buf
    import poseidon2_pkg::*;
#(
    parameter int ELEM_W = poseidon2_pkg::ELEM_W,
    parameter int DEPTH  = poseidon2_pkg::MAX_ELEMS
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [3:0]        wr_ptr,
    input  logic [ELEM_W-1:0] wr_data,
    input  logic [3:0]        rd_idx,
    output logic [ELEM_W-1:0] rd_data
);

    logic [ELEM_W-1:0] mem [DEPTH];

    // Element storage carries no reset; only the counters in the top qualify it.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_ptr) < DEPTH)) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = (32'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/poseidon2_hash_initiator.sv
// rtl/poseidon2_hash_initiator.sv - collects a message, drives the Poseidon2 core, returns the digest
module poseidon2_hash_initiator
    import poseidon2_pkg::*;
#(
    parameter int ELEM_W    = poseidon2_pkg::ELEM_W,
    parameter int MAX_ELEMS = poseidon2_pkg::MAX_ELEMS,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_last,
    output logic              res_valid,
    input  logic              res_ready,
    output digest_t           res_hash,
    output logic [3:0]        res_size,
    output logic [1:0]        res_err,
    output logic              core_start,
    output logic [3:0]        core_size,
    output logic              core_elem_valid,
    input  logic              core_elem_ready,
    output logic [ELEM_W-1:0] core_elem_data,
    input  logic              core_done,
    input  digest_t           core_hash
);

    localparam int TW = $clog2(TIMEOUT);

    init_state_e       state, state_nx;
    logic [3:0]        cnt, idx;
    logic [TW-1:0]     tcnt;
    hash_err_e         err;
    digest_t           hash_q;
    logic              done_q;
    logic              done_rise, in_hs, elem_hs, tmo, last_idx, full_hit;
    logic [ELEM_W-1:0] rd_data;

    assign done_rise = core_done && !done_q;
    assign in_hs     = in_valid && in_ready;
    assign elem_hs   = core_elem_valid && core_elem_ready;
    assign tmo       = (tcnt == TW'(TIMEOUT - 1));
    assign last_idx  = (idx == cnt - 4'd1);
    assign full_hit  = (cnt == 4'(MAX_ELEMS - 1));

    poseidon2_msg_buf #(.ELEM_W(ELEM_W), .DEPTH(MAX_ELEMS)) u_buf (
        .clk     (clk),
        .wr_en   (in_hs),
        .wr_ptr  (cnt),
        .wr_data (in_data),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    assign res_hash       = hash_q;
    assign res_size       = cnt;
    assign res_err        = err;
    assign core_size      = cnt;
    assign core_elem_data = (state == ST_FEED) ? rd_data : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; done beats timeout beats the last feed handshake.
    always_comb begin
        state_nx        = state;
        in_ready        = 1'b0;
        core_start      = 1'b0;
        core_elem_valid = 1'b0;
        res_valid       = 1'b0;
        case (state)
            ST_IDLE, ST_COLLECT: begin
                in_ready = !rst;
                if (in_hs) begin
                    if (in_last || full_hit) begin
                        state_nx = ST_START;
                    end else begin
                        state_nx = ST_COLLECT;
                    end
                end
            end
            ST_START: begin
                core_start = 1'b1;
                state_nx   = ST_FEED;
            end
            ST_FEED: begin
                core_elem_valid = 1'b1;
                if (done_rise || tmo) begin
                    state_nx = ST_RESULT;
                end else if (core_elem_ready && last_idx) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_rise || tmo) begin
                    state_nx = ST_RESULT;
                end
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Counters, sticky first error, digest capture and done edge tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            tcnt   <= '0;
            err    <= HASH_OK;
            hash_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= core_done;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (in_hs) begin
                        cnt <= cnt + 4'd1;
                        if (!in_last && full_hit) begin
                            err <= HASH_OVERFLOW;
                        end
                    end
                end
                ST_START: begin
                    tcnt <= '0;
                end
                ST_FEED, ST_WAIT: begin
                    if (!(&tcnt)) begin
                        tcnt <= tcnt + 1'b1;
                    end
                    if ((state == ST_FEED) && elem_hs) begin
                        idx <= idx + 4'd1;
                    end
                    if (done_rise) begin
                        hash_q <= core_hash;
                        if ((state == ST_FEED) && (err == HASH_OK)) begin
                            err <= HASH_EARLY_DONE;
                        end
                    end else if (tmo) begin
                        hash_q <= '0;
                        if (err == HASH_OK) begin
                            err <= HASH_TIMEOUT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        cnt <= '0;
                        idx <= '0;
                        err <= HASH_OK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
